// File: rtl/bus_pkg.sv
// Shared constants and helpers for bus multiplexing and priority encoding.
package bus_pkg;

    localparam int unsigned MODE_PRIORITY = 0;
    localparam int unsigned MODE_STRICT   = 1;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NSRC  = 24;

    // Helpers work on a fixed-width vector; callers zero-extend into it.
    localparam int unsigned MAX_NSRC  = 64;
    localparam int unsigned MAX_SEL_W = 6;

    // Index of the lowest set bit, 0 when the vector is empty.
    function automatic logic [MAX_SEL_W-1:0] lowest_set(input logic [MAX_NSRC-1:0] v);
        logic [MAX_SEL_W-1:0] idx;
        idx = '0;
        for (int i = MAX_NSRC - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = MAX_SEL_W'(i);
            end
        end
        return idx;
    endfunction

    // True when more than one bit is set: clearing the lowest set bit leaves something.
    function automatic logic multi_set(input logic [MAX_NSRC-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/bus_prio_enc.sv
// Combinational priority encoder: lowest set index wins, plus empty and multi flags.
module bus_prio_enc
    import bus_pkg::*;
#(
    parameter int unsigned NSRC  = DEF_NSRC,
    parameter int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0]  en,
    output logic [SEL_W-1:0] sel,
    output logic             none,
    output logic             multi
);

    logic [MAX_NSRC-1:0] en_ext;

    // Widen the enable vector to the helper width and decode it.
    always_comb begin
        en_ext           = '0;
        en_ext[NSRC-1:0] = en;
        sel              = SEL_W'(lowest_set(en_ext));
        none             = (en == '0);
        multi            = multi_set(en_ext);
    end

endmodule

// File: rtl/bus_mux_reg.sv
// Registered bus multiplexer with override table, conflict flags and transfer counter.
module bus_mux_reg
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NSRC  = DEF_NSRC,
    parameter int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int unsigned MODE  = MODE_PRIORITY,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [NSRC-1:0]   src_en,
    input  logic [NSRC*WIDTH-1:0] src_data,
    input  logic              ovr_wr,
    input  logic              ovr_clr,
    input  logic [SEL_W-1:0]  ovr_idx,
    input  logic [WIDTH-1:0]  ovr_data,
    input  logic              conflict_ack,
    output logic [WIDTH-1:0]  bus_out,
    output logic              bus_valid,
    output logic [SEL_W-1:0]  bus_src,
    output logic              conflict,
    output logic              conflict_sticky,
    output logic [CNT_W-1:0]  xfer_count
);

    logic [SEL_W-1:0] sel;
    logic             none;
    logic             multi;
    logic             accept;
    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] src_word [NSRC];

    logic [NSRC-1:0]  ovr_en_q;
    logic [WIDTH-1:0] ovr_val_q [NSRC];

    logic [WIDTH-1:0] bus_out_q;
    logic             bus_valid_q;
    logic [SEL_W-1:0] bus_src_q;
    logic             conflict_q;
    logic             sticky_q;
    logic [CNT_W-1:0] count_q;

    bus_prio_enc #(
        .NSRC  (NSRC),
        .SEL_W (SEL_W)
    ) u_enc (
        .en    (src_en),
        .sel   (sel),
        .none  (none),
        .multi (multi)
    );

    // Unpack the flattened source bus, pick the winner and apply any override.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_word[i] = src_data[i*WIDTH +: WIDTH];
        end
        accept  = !none && ((MODE == MODE_STRICT) ? !multi : 1'b1);
        sel_val = ovr_en_q[sel] ? ovr_val_q[sel] : src_word[sel];
    end

    // Override table; indices past the last source match no entry and are dropped.
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < NSRC; i++) begin
                ovr_en_q[i]  <= 1'b0;
                ovr_val_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (ovr_idx == SEL_W'(i)) begin
                    if (ovr_wr) begin
                        ovr_en_q[i]  <= 1'b1;
                        ovr_val_q[i] <= ovr_data;
                    end else if (ovr_clr) begin
                        ovr_en_q[i]  <= 1'b0;
                    end
                end
            end
        end
    end

    // Bus register: load on accept, otherwise hold data/source and drop valid.
    always_ff @(posedge clk) begin
        if (clear) begin
            bus_out_q   <= '0;
            bus_src_q   <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                bus_out_q <= sel_val;
                bus_src_q <= sel;
            end
            bus_valid_q <= accept;
        end
    end

    // Conflict pulse and sticky flag; a new conflict beats an acknowledge.
    always_ff @(posedge clk) begin
        if (clear) begin
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            conflict_q <= multi;
            if (multi) begin
                sticky_q <= 1'b1;
            end else if (conflict_ack) begin
                sticky_q <= 1'b0;
            end
        end
    end

    // Saturating count of accepted transfers.
    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (accept && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign bus_out         = bus_out_q;
    assign bus_valid       = bus_valid_q;
    assign bus_src         = bus_src_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign xfer_count      = count_q;

endmodule
